// File: rtl/tinst_sched_pkg.sv
// Shared encodings, field widths and the packed instruction word for the tensor scheduler.
// Pure declarations: no logic, no latency, no flow control.
package tinst_sched_pkg;

   localparam int TINST_TYPE_WIDTH     = 2;
   localparam int TLOAD_DATAW_WIDTH    = 2;
   localparam int TMMA_PRECISION_WIDTH = 2;
   localparam int ADDR_WIDTH           = 32;

   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADA = 2'd1;
   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADC = 2'd2;
   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_TMMA     = 2'd3;

   typedef struct packed {
      logic [TINST_TYPE_WIDTH-1:0]     ttype;
      logic [TLOAD_DATAW_WIDTH-1:0]    dw;
      logic [ADDR_WIDTH-1:0]           addr0;
      logic [ADDR_WIDTH-1:0]           addr1;
      logic [TMMA_PRECISION_WIDTH-1:0] prec;
      logic                            acc;
   } tinst_t;

   typedef enum logic {
      OUT_EMPTY  = 1'b0,
      OUT_LOADED = 1'b1
   } out_state_e;

endpackage

// File: rtl/tinst_fifo.sv
// Generic synchronous FIFO with wrap-around pointers carrying an extra MSB.
// Latency: write visible at head one cycle after push; read data is the combinational head.
// Backpressure: caller must not push when full nor pop when empty; push+pop when full is legal.
module tinst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdat,
   input  logic             pop,
   output logic [WIDTH-1:0] rdat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdat;
   end

   assign rdat  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tinst_sched.sv
// In-order tensor-instruction scheduler: FIFO + one output register, drops unsatisfiable heads.
// Latency: 2 cycles push->issue_tinst_valid_o, then 1 issue/cycle; optional counters via TINST_SCHED_PERF_EN.
// Backpressure: output held stable while ~issue_tinst_ready_i; dec_tinst_ready_o = FIFO not full.
module tinst_sched
   import tinst_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int A_BUF_NUM  = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            dec_tinst_valid_i,
   output logic                            dec_tinst_ready_o,
   input  logic [TINST_TYPE_WIDTH-1:0]     dec_tinst_type_i,
   input  logic [TLOAD_DATAW_WIDTH-1:0]    dec_tinst_dw_i,
   input  logic [ADDR_WIDTH-1:0]           dec_tinst_addr0_i,
   input  logic [ADDR_WIDTH-1:0]           dec_tinst_addr1_i,
   input  logic [TMMA_PRECISION_WIDTH-1:0] dec_tinst_prec_i,
   input  logic                            dec_tinst_acc_i,
   output logic                            issue_tinst_valid_o,
   input  logic                            issue_tinst_ready_i,
   output logic [TINST_TYPE_WIDTH-1:0]     issue_tinst_type_o,
   output logic [TLOAD_DATAW_WIDTH-1:0]    issue_tinst_dw_o,
   output logic [ADDR_WIDTH-1:0]           issue_tinst_addr0_o,
   output logic [ADDR_WIDTH-1:0]           issue_tinst_addr1_o,
   output logic [TMMA_PRECISION_WIDTH-1:0] issue_tinst_prec_o,
   output logic                            issue_tinst_acc_o,
   output logic                            sched_err_o,
   output logic                            sched_idle_o
`ifdef TINST_SCHED_PERF_EN
   ,
   output logic [31:0]                     perf_issue_o,
   output logic [31:0]                     perf_stall_o,
   output logic [31:0]                     perf_drop_o
`endif
);

   localparam int              ACW       = $clog2(A_BUF_NUM + 1);
   localparam logic [ACW-1:0]  A_CNT_MAX = A_BUF_NUM[ACW-1:0];
   localparam logic [ACW:0]    A_PEND_MAX = A_BUF_NUM[ACW:0];

   tinst_t     push_dat, head, out_q;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   out_state_e state_q, state_d;
   logic       out_vld, out_load, hs;
   logic       head_elig, head_drop;
   logic [ACW-1:0] a_cnt;
   logic [ACW:0]   a_pend;
   logic       c_valid, c_pend, out_pa, out_tm, err_q;

   assign push_dat = '{ttype: dec_tinst_type_i, dw: dec_tinst_dw_i, addr0: dec_tinst_addr0_i,
                       addr1: dec_tinst_addr1_i, prec: dec_tinst_prec_i, acc: dec_tinst_acc_i};
   assign fifo_push = dec_tinst_valid_i & ~fifo_full;
   assign fifo_pop  = out_load | head_drop;

   tinst_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(tinst_t))) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdat  (push_dat),
      .pop   (fifo_pop),
      .rdat  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_vld = (state_q == OUT_LOADED);
   assign hs      = out_vld & issue_tinst_ready_i;
   assign out_pa  = out_vld & (out_q.ttype == TINST_TYPE_PRELOADA);
   assign out_tm  = out_vld & (out_q.ttype == TINST_TYPE_TMMA);
   // Out-stage contents are committed already, so count them as if issued; this keeps a
   // TMMA(acc) behind a not-yet-handshaked PRELOADC/TMMA from being dropped spuriously.
   assign a_pend  = {1'b0, a_cnt} + {{ACW{1'b0}}, out_pa} - {{ACW{1'b0}}, out_tm};
   assign c_pend  = c_valid | (out_vld & (out_q.ttype == TINST_TYPE_PRELOADC)) | out_tm;

   always_comb begin
      head_elig = 1'b0;
      head_drop = 1'b0;
      if (!fifo_empty) begin
         case (head.ttype)
            TINST_TYPE_PRELOADA: head_elig = (a_pend < A_PEND_MAX);
            TINST_TYPE_PRELOADC: head_elig = 1'b1;
            TINST_TYPE_TMMA: begin
               if ((a_pend == '0) || (head.acc && !c_pend)) head_drop = 1'b1;
               else                                         head_elig = 1'b1;
            end
            default: head_drop = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      out_load = 1'b0;
      case (state_q)
         OUT_EMPTY: begin
            if (head_elig) begin
               out_load = 1'b1;
               state_d  = OUT_LOADED;
            end
         end
         OUT_LOADED: begin
            if (hs) begin
               if (head_elig) out_load = 1'b1;
               else           state_d  = OUT_EMPTY;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OUT_EMPTY;
         out_q   <= '0;
         a_cnt   <= '0;
         c_valid <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= head_drop;
         if (out_load) out_q <= head;
         if (hs) begin
            case (out_q.ttype)
               TINST_TYPE_PRELOADA: if (a_cnt < A_CNT_MAX) a_cnt <= a_cnt + 1'b1;
               TINST_TYPE_TMMA: begin
                  if (a_cnt != '0) a_cnt <= a_cnt - 1'b1;
                  c_valid <= 1'b1;
               end
               TINST_TYPE_PRELOADC: c_valid <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign dec_tinst_ready_o   = ~fifo_full;
   assign issue_tinst_valid_o = out_vld;
   assign issue_tinst_type_o  = out_q.ttype;
   assign issue_tinst_dw_o    = out_q.dw;
   assign issue_tinst_addr0_o = out_q.addr0;
   assign issue_tinst_addr1_o = out_q.addr1;
   assign issue_tinst_prec_o  = out_q.prec;
   assign issue_tinst_acc_o   = out_q.acc;
   assign sched_err_o         = err_q;
   assign sched_idle_o        = fifo_empty & ~out_vld;

`ifdef TINST_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_o <= '0;
         perf_stall_o <= '0;
         perf_drop_o  <= '0;
      end else begin
         if (hs)        perf_issue_o <= perf_issue_o + 1'b1;
         if (head_drop) perf_drop_o  <= perf_drop_o + 1'b1;
         if (!fifo_empty && !head_elig && !head_drop) perf_stall_o <= perf_stall_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tinst_sched.sv
// Directed bench for tinst_sched: ordering, latency, drops, stalls, full FIFO and async reset.
module tb_tinst_sched;
   import tinst_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dec_valid = 1'b0;
   logic        dec_ready;
   logic [1:0]  dec_type = '0;
   logic [1:0]  dec_dw = 2'd2;
   logic [31:0] dec_a0 = '0;
   logic [31:0] dec_a1 = '0;
   logic [1:0]  dec_prec = 2'd1;
   logic        dec_acc = 1'b0;
   logic        iss_valid;
   logic        iss_ready = 1'b1;
   logic [1:0]  iss_type_o;
   logic [1:0]  iss_dw_o;
   logic [31:0] iss_a0_o;
   logic [31:0] iss_a1_o;
   logic [1:0]  iss_prec_o;
   logic        iss_acc_o;
   logic        err;
   logic        idle;
`ifdef TINST_SCHED_PERF_EN
   logic [31:0] perf_issue, perf_stall, perf_drop;
   logic [31:0] stall_snap;
`endif

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int last_push;
   int base_i, base_e, rel;

   int          n_iss = 0;
   int          n_err = 0;
   logic [1:0]  rec_type [64];
   logic [31:0] rec_a0   [64];
   logic [31:0] rec_a1   [64];
   int          rec_edge [64];

   tinst_sched dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .dec_tinst_valid_i   (dec_valid),
      .dec_tinst_ready_o   (dec_ready),
      .dec_tinst_type_i    (dec_type),
      .dec_tinst_dw_i      (dec_dw),
      .dec_tinst_addr0_i   (dec_a0),
      .dec_tinst_addr1_i   (dec_a1),
      .dec_tinst_prec_i    (dec_prec),
      .dec_tinst_acc_i     (dec_acc),
      .issue_tinst_valid_o (iss_valid),
      .issue_tinst_ready_i (iss_ready),
      .issue_tinst_type_o  (iss_type_o),
      .issue_tinst_dw_o    (iss_dw_o),
      .issue_tinst_addr0_o (iss_a0_o),
      .issue_tinst_addr1_o (iss_a1_o),
      .issue_tinst_prec_o  (iss_prec_o),
      .issue_tinst_acc_o   (iss_acc_o),
      .sched_err_o         (err),
      .sched_idle_o        (idle)
`ifdef TINST_SCHED_PERF_EN
      ,
      .perf_issue_o        (perf_issue),
      .perf_stall_o        (perf_stall),
      .perf_drop_o         (perf_drop)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake seen at a negedge completes at the next posedge, numbered cyc+1.
   always @(negedge clk) begin
      if (iss_valid && iss_ready && n_iss < 64) begin
         rec_type[n_iss] <= iss_type_o;
         rec_a0[n_iss]   <= iss_a0_o;
         rec_a1[n_iss]   <= iss_a1_o;
         rec_edge[n_iss] <= cyc + 1;
         n_iss           <= n_iss + 1;
      end
      if (err) n_err <= n_err + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Caller is aligned 1 time unit after a posedge; returns likewise, pushes back-to-back.
   task automatic push(input logic [1:0] ty, input logic [31:0] a0, input logic [31:0] a1,
                       input logic acc);
      dec_valid = 1'b1;
      dec_type  = ty;
      dec_a0    = a0;
      dec_a1    = a1;
      dec_acc   = acc;
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
      last_push = cyc;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      iss_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", iss_valid, 0);
      chk("rst_err",   err, 0);
      chk("rst_idle",  idle, 1);
      chk("rst_ready", dec_ready, 1);

      // In-order PRELOADA, PRELOADC, TMMA(acc=0)
      base_i = n_iss; base_e = n_err;
      push(TINST_TYPE_PRELOADA, 32'h100, 32'h0, 1'b0);
      rel = last_push;
      push(TINST_TYPE_PRELOADC, 32'h200, 32'h0, 1'b0);
      push(TINST_TYPE_TMMA, 32'h0, 32'h300, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("seq_count", n_iss - base_i, 3);
      chk("seq_t0", rec_type[base_i], TINST_TYPE_PRELOADA);
      chk("seq_t1", rec_type[base_i+1], TINST_TYPE_PRELOADC);
      chk("seq_t2", rec_type[base_i+2], TINST_TYPE_TMMA);
      chk("seq_a0", rec_a0[base_i], 32'h100);
      chk("seq_a1", rec_a1[base_i+2], 32'h300);
      chk("seq_e0", rec_edge[base_i] - rel, 2);
      chk("seq_e1", rec_edge[base_i+1] - rel, 3);
      chk("seq_e2", rec_edge[base_i+2] - rel, 4);
      chk("seq_err", n_err - base_e, 0);
      chk("seq_idle", idle, 1);

      // TMMA with no A loaded is dropped
      do_reset();
      base_i = n_iss; base_e = n_err;
      push(TINST_TYPE_TMMA, 32'h0, 32'h400, 1'b0);
      chk("drop_err_pre", err, 0);
      @(posedge clk); #1;
      chk("drop_err_pulse", err, 1);
      @(posedge clk); #1;
      chk("drop_err_clr", err, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("drop_issued", n_iss - base_i, 0);
      chk("drop_errcnt", n_err - base_e, 1);
      chk("drop_idle", idle, 1);
`ifdef TINST_SCHED_PERF_EN
      chk("drop_perf", perf_drop, 1);
`endif

      // TMMA(acc=1) without valid C is dropped after its PRELOADA issues
      do_reset();
      base_i = n_iss; base_e = n_err;
      push(TINST_TYPE_PRELOADA, 32'h500, 32'h0, 1'b0);
      push(TINST_TYPE_TMMA, 32'h0, 32'h600, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("acc_issued", n_iss - base_i, 1);
      chk("acc_type", rec_type[base_i], TINST_TYPE_PRELOADA);
      chk("acc_err", n_err - base_e, 1);
      chk("acc_idle", idle, 1);

      // Third PRELOADA exceeds the ping-pong and blocks the queue
      do_reset();
      base_i = n_iss; base_e = n_err;
      push(TINST_TYPE_PRELOADA, 32'h10, 32'h0, 1'b0);
      push(TINST_TYPE_PRELOADA, 32'h20, 32'h0, 1'b0);
      push(TINST_TYPE_PRELOADA, 32'h30, 32'h0, 1'b0);
      push(TINST_TYPE_TMMA, 32'h0, 32'h40, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("stall_issued", n_iss - base_i, 2);
      chk("stall_err", n_err - base_e, 0);
      chk("stall_idle", idle, 0);
      chk("stall_valid", iss_valid, 0);
`ifdef TINST_SCHED_PERF_EN
      stall_snap = perf_stall;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_perf_grow", perf_stall - stall_snap, 5);
      chk("stall_perf_issue", perf_issue, 2);
`endif

      // Fill FIFO under backpressure, then drain at one per cycle
      do_reset();
      iss_ready = 1'b0;
      base_i = n_iss; base_e = n_err;
      push(TINST_TYPE_PRELOADA, 32'h11, 32'h0, 1'b0);
      push(TINST_TYPE_PRELOADC, 32'h22, 32'h0, 1'b0);
      push(TINST_TYPE_TMMA, 32'h0, 32'h33, 1'b1);
      push(TINST_TYPE_PRELOADA, 32'h44, 32'h0, 1'b0);
      chk("fill_ready_4", dec_ready, 1);
      push(TINST_TYPE_PRELOADC, 32'h55, 32'h0, 1'b0);
      chk("fill_ready_5", dec_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("fill_hold_valid", iss_valid, 1);
      chk("fill_hold_a0", iss_a0_o, 32'h11);
      chk("fill_ready_hold", dec_ready, 0);
      iss_ready = 1'b1;
      rel = cyc;
      repeat (8) @(posedge clk);
      #1;
      chk("drain_count", n_iss - base_i, 5);
      chk("drain_first", rec_edge[base_i] - rel, 1);
      chk("drain_span", rec_edge[base_i+4] - rec_edge[base_i], 4);
      chk("drain_t2", rec_type[base_i+2], TINST_TYPE_TMMA);
      chk("drain_a0_4", rec_a0[base_i+4], 32'h55);
      chk("drain_err", n_err - base_e, 0);
      chk("drain_idle", idle, 1);

      // Async reset while an instruction is held in the output stage
      iss_ready = 1'b0;
      push(TINST_TYPE_PRELOADA, 32'h77, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("ar_valid_pre", iss_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", iss_valid, 0);
      chk("ar_idle", idle, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      iss_ready = 1'b1;
      base_i = n_iss;
      repeat (6) @(posedge clk);
      #1;
      chk("ar_no_issue", n_iss - base_i, 0);
      chk("ar_ready", dec_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
